// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory port arbiter: FSM states, master ids, counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

  localparam int LAT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick; zero latency, no backpressure (pure function of inputs).
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_id,
  output logic       any
);

  always_comb begin
    any    = |req;
    gnt_id = M_CPU;
    if (req == 2'b11) begin
      gnt_id = ~last;
    end else if (req[1]) begin
      gnt_id = M_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory port between CPU (M0) and loader (M1); ack arrives MEM_LAT+1 cycles after grant.
// Requesters hold req until their one-cycle ack; requests are only sampled in IDLE, one transaction at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    m_req,
  input  logic [1:0]    m_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wd,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wd,
  output logic [1:0]    m_ack,
  output logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [AW-1:0]    txn_adr_q, txn_adr_d;
  logic [DW-1:0]    txn_wd_q, txn_wd_d;
  logic             txn_we_q, txn_we_d;
  logic             txn_id_q, txn_id_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic gnt_id;
  logic any_req;

  rr_arb2 u_rr_arb2 (
    .req    (m_req),
    .last   (last_q),
    .gnt_id (gnt_id),
    .any    (any_req)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    txn_adr_d = txn_adr_q;
    txn_wd_d  = txn_wd_q;
    txn_we_d  = txn_we_q;
    txn_id_d  = txn_id_q;
    lat_d     = lat_q;
    rdata_d   = rdata_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          txn_adr_d = gnt_id ? m1_adr : m0_adr;
          txn_wd_d  = gnt_id ? m1_wd  : m0_wd;
          txn_we_d  = m_we[gnt_id];
          txn_id_d  = gnt_id;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        lat_d = LAT_W'(MEM_LAT - 1);
        if (MEM_LAT == 1) begin
          rdata_d = mem_rd;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          rdata_d = mem_rd;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = txn_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= M_LDR;
      txn_adr_q <= '0;
      txn_wd_q  <= '0;
      txn_we_q  <= 1'b0;
      txn_id_q  <= M_CPU;
      lat_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      txn_adr_q <= txn_adr_d;
      txn_wd_q  <= txn_wd_d;
      txn_we_q  <= txn_we_d;
      txn_id_q  <= txn_id_d;
      lat_q     <= lat_d;
      rdata_q   <= rdata_d;
    end
  end

  // The transaction register only changes on grant, so it doubles as the held memory address/data.
  always_comb begin
    mem_adr = txn_adr_q;
    mem_wd  = txn_wd_q;
    mem_we  = (state_q == ACCESS) && txn_we_q;
    busy    = (state_q != IDLE);
    m_ack   = 2'b00;
    m_rdata = '0;
    if (state_q == DONE) begin
      m_ack   = txn_id_q ? 2'b10 : 2'b01;
      m_rdata = rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and scoreboard bench for mem_port_arbiter at MEM_LAT 1, 2, 3 and 5.
module tb_mem_port_arbiter;

  localparam int NI = 4;
  localparam int LAT_TAB [NI] = '{1, 2, 3, 5};

  logic        clk;
  logic        rst;
  logic        req0 [NI];
  logic        req1 [NI];
  logic        we0 [NI];
  logic        we1 [NI];
  logic [31:0] m0_adr [NI];
  logic [31:0] m0_wd [NI];
  logic [31:0] m1_adr [NI];
  logic [31:0] m1_wd [NI];
  logic [1:0]  m_ack [NI];
  logic [31:0] m_rdata [NI];
  logic        busy [NI];
  logic [31:0] mem_adr [NI];
  logic [31:0] mem_wd [NI];
  logic        mem_we [NI];
  logic [31:0] mem_rd [NI];

  logic [31:0] mem [NI][256];
  logic [31:0] ref_mem [NI][256];

  int n_chk;
  int n_fail;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(
      .AW      (32),
      .DW      (32),
      .MEM_LAT (LAT_TAB[g])
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .m_req   ({req1[g], req0[g]}),
      .m_we    ({we1[g], we0[g]}),
      .m0_adr  (m0_adr[g]),
      .m0_wd   (m0_wd[g]),
      .m1_adr  (m1_adr[g]),
      .m1_wd   (m1_wd[g]),
      .m_ack   (m_ack[g]),
      .m_rdata (m_rdata[g]),
      .busy    (busy[g]),
      .mem_adr (mem_adr[g]),
      .mem_wd  (mem_wd[g]),
      .mem_we  (mem_we[g]),
      .mem_rd  (mem_rd[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int w);
    if (w == 16) return 32'hDEADBEEF;
    return 32'hC0DE0000 | w;
  endfunction

  // Word-addressed memory model; address is stable for the whole access so reads are combinational.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++)
        for (int k = 0; k < 256; k++) mem[i][k] <= init_word(k);
    end else begin
      for (int i = 0; i < NI; i++)
        if (mem_we[i]) mem[i][mem_adr[i][9:2]] <= mem_wd[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) mem_rd[i] = mem[i][mem_adr[i][9:2]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst && m_ack[i] != 2'b00) begin
        chk("ack_1hot", 64'(m_ack[i] == 2'b11), 64'd0);
        chk("ack_nowe", 64'(mem_we[i]), 64'd0);
      end
    end
  end

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_master(input int k, input int m, input int nops);
    logic        we;
    logic [31:0] wd;
    int          widx;
    int          fcnt;
    bit          got;
    for (int n = 0; n < nops; n++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      we   = 1'($urandom_range(0, 1));
      widx = $urandom_range(0, 15);
      wd   = $urandom;
      if (m == 0) begin
        m0_adr[k] = 32'(widx * 4); m0_wd[k] = wd; we0[k] = we; req0[k] = 1'b1;
      end else begin
        m1_adr[k] = 32'(widx * 4); m1_wd[k] = wd; we1[k] = we; req1[k] = 1'b1;
      end
      fcnt = 0;
      got  = 1'b0;
      for (int t = 0; t < 64 && !got; t++) begin
        @(negedge clk);
        if (m_ack[k][1-m]) fcnt++;
        if (m_ack[k][m]) got = 1'b1;
      end
      chk("sb_ack", 64'(got), 64'd1);
      if (got) begin
        if (we) ref_mem[k][widx] = wd;
        else chk("sb_rdata", 64'(m_rdata[k]), 64'(ref_mem[k][widx]));
        chk("sb_wait", 64'(fcnt <= 1), 64'd1);
      end
      if (m == 0) req0[k] = 1'b0;
      else req1[k] = 1'b0;
    end
  endtask

  int acks;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    for (int i = 0; i < NI; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0; we0[i] = 1'b0; we1[i] = 1'b0;
      m0_adr[i] = '0; m0_wd[i] = '0; m1_adr[i] = '0; m1_wd[i] = '0;
    end
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(m_ack[0]), 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_we", 64'(mem_we[0]), 64'd0);
    chk("rst_adr", 64'(mem_adr[0]), 64'd0);
    chk("rst_wd", 64'(mem_wd[0]), 64'd0);
    chk("rst_rdata", 64'(m_rdata[0]), 64'd0);
    rst = 1'b1;

    // Reset asserted mid-WAIT with an M1 write in flight (MEM_LAT=3).
    @(negedge clk);
    req1[2] = 1'b1; we1[2] = 1'b1; m1_adr[2] = 32'h200; m1_wd[2] = 32'hCAFEF00D;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t1_busy", 64'(busy[2]), 64'd0);
    chk("t1_ack", 64'(m_ack[2]), 64'd0);
    chk("t1_adr", 64'(mem_adr[2]), 64'd0);
    chk("t1_wd", 64'(mem_wd[2]), 64'd0);
    chk("t1_we", 64'(mem_we[2]), 64'd0);
    @(negedge clk);
    req1[2] = 1'b0; we1[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_ack[2] != 2'b00) acks++;
    end
    chk("t1_noack", 64'(acks), 64'd0);

    // Single read, MEM_LAT=1.
    req0[0] = 1'b1; we0[0] = 1'b0; m0_adr[0] = 32'h40;
    @(negedge clk);
    chk("t2_adr", 64'(mem_adr[0]), 64'h40);
    chk("t2_busy", 64'(busy[0]), 64'd1);
    chk("t2_ack_early", 64'(m_ack[0]), 64'd0);
    chk("t2_we1", 64'(mem_we[0]), 64'd0);
    @(negedge clk);
    chk("t2_ack", 64'(m_ack[0]), 64'h1);
    chk("t2_rdata", 64'(m_rdata[0]), 64'hDEADBEEF);
    chk("t2_we2", 64'(mem_we[0]), 64'd0);
    req0[0] = 1'b0;
    @(negedge clk);
    chk("t2_noreissue", 64'(busy[0]), 64'd0);
    chk("t2_ack_after", 64'(m_ack[0]), 64'd0);

    // Write, MEM_LAT=3.
    req1[2] = 1'b1; we1[2] = 1'b1; m1_adr[2] = 32'h100; m1_wd[2] = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("t3_we_c%0d", c), 64'(mem_we[2]), 64'(c == 1));
      chk($sformatf("t3_ack_c%0d", c), 64'(m_ack[2]), (c == 4) ? 64'h2 : 64'h0);
      if (c <= 3) chk($sformatf("t3_adr_c%0d", c), 64'(mem_adr[2]), 64'h100);
      if (c == 4) begin
        req1[2] = 1'b0; we1[2] = 1'b0;
      end
    end
    chk("t3_mem", 64'(mem[2][64]), 64'h12345678);

    // Contention right after reset, MEM_LAT=1: M0,M1,M0,M1 three cycles apart.
    rst_pulse();
    req0[0] = 1'b1; we0[0] = 1'b0; m0_adr[0] = 32'h40;
    req1[0] = 1'b1; we1[0] = 1'b0; m1_adr[0] = 32'h44;
    for (int c = 1; c <= 12; c++) begin
      logic [1:0] exp_ack;
      @(negedge clk);
      exp_ack = 2'b00;
      if (c % 3 == 2) exp_ack = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("t4_ack_c%0d", c), 64'(m_ack[0]), 64'(exp_ack));
      if (exp_ack == 2'b01) chk("t4_rd0", 64'(m_rdata[0]), 64'hDEADBEEF);
      if (exp_ack == 2'b10) chk("t4_rd1", 64'(m_rdata[0]), 64'hC0DE0011);
      if (c == 11) begin
        req0[0] = 1'b0; req1[0] = 1'b0;
      end
    end

    // Request withdrawn during ACCESS, MEM_LAT=2.
    req0[1] = 1'b1; we0[1] = 1'b0; m0_adr[1] = 32'h48;
    @(negedge clk);
    req0[1] = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("t5_ack_c%0d", c), 64'(m_ack[1]), (c == 3) ? 64'h1 : 64'h0);
      if (c == 3) chk("t5_rdata", 64'(m_rdata[1]), 64'hC0DE0012);
    end

    // Random two-master traffic against a reference memory.
    for (int s = 0; s < 3; s++) begin
      int k;
      k = (s == 0) ? 0 : (s == 1) ? 1 : 3;
      rst_pulse();
      for (int w = 0; w < 256; w++) ref_mem[k][w] = init_word(w);
      fork
        run_master(k, 0, 167);
        run_master(k, 1, 167);
      join
      repeat (3) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
